// File: rtl/mips_mem_arbiter_if.sv
// Requester, response and memory-side bus of mips_mem_arbiter.
// d_err exists only when MEM_ARB_ALIGN_CHECK_EN is defined.
interface mips_mem_arbiter_if;
    // Handshake: a requester raises *_req with its fields stable and holds them
    // until *_gnt is sampled high at a posedge (that cycle is ISSUE). Exactly one
    // cycle later *_valid pulses for one cycle (RESP) carrying *_rdata/d_err.
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_byte_en;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        d_err;
`endif
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_wr_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_byte_en, d_wdata, mem_data_out,
`ifdef MEM_ARB_ALIGN_CHECK_EN
        input  d_err,
`endif
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  mem_address, mem_read_en, mem_wr_en, mem_byte_en, mem_data_in, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_byte_en, d_wdata, mem_data_out,
`ifdef MEM_ARB_ALIGN_CHECK_EN
        output d_err,
`endif
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output mem_address, mem_read_en, mem_wr_en, mem_byte_en, mem_data_in, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-port (fetch I / data D) arbiter for the single-port MIPS memory; ISSUE+RESP per access.
// Optional MEM_ARB_ALIGN_CHECK_EN rejects misaligned requests without touching memory.
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    mips_mem_arbiter_if.slave  bus,
    output logic [0:0]         dbg_state,
    output logic [CNT_W-1:0]   dbg_starve_cnt
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             issue, i_win, d_win, i_rej, d_rej, resp;

    always_comb begin : arbitrate
        issue = (state_q == ST_IDLE) && active && !reset && (bus.i_req || bus.d_req);
        i_win = issue && bus.i_req && (!bus.d_req || (starve_cnt_q >= LIMIT));
        d_win = issue && !i_win;
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    always_comb begin : align_check
        i_rej = i_win && (bus.i_addr[1:0] != 2'b00);
        d_rej = d_win && (((bus.d_byte_en == 4'b1111) && (bus.d_addr[1:0] != 2'b00)) ||
                          (((bus.d_byte_en == 4'b0011) || (bus.d_byte_en == 4'b1100)) &&
                           bus.d_addr[0]));
    end
`else
    assign i_rej = 1'b0;
    assign d_rej = 1'b0;
`endif

    assign bus.i_gnt = i_win;
    assign bus.d_gnt = d_win;

    // A rejected grant still completes the handshake but leaves the memory untouched.
    always_comb begin : mem_drive
        bus.mem_address = '0;
        bus.mem_read_en = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_byte_en = '0;
        bus.mem_data_in = '0;
        if (i_win && !i_rej) begin
            bus.mem_address = bus.i_addr;
            bus.mem_read_en = 1'b1;
            bus.mem_byte_en = 4'b1111;
        end else if (d_win && !d_rej) begin
            bus.mem_address = bus.d_addr;
            bus.mem_byte_en = bus.d_byte_en;
            if (bus.d_we) begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = bus.d_wdata;
            end else begin
                bus.mem_read_en = 1'b1;
            end
        end
    end

    // The non-owning port keeps showing its last delivered word.
    always_comb begin : respond
        resp        = (state_q == ST_RESP) && !reset;
        bus.i_valid = resp && (owner_q == OWN_I);
        bus.d_valid = resp && (owner_q == OWN_D);
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (bus.i_valid) begin
            i_rdata_d = err_q ? 32'h0 : bus.mem_data_out;
        end
        if (bus.d_valid && !we_q && !err_q) begin
            d_rdata_d = bus.mem_data_out;
        end
        bus.i_rdata = i_rdata_d;
        bus.d_rdata = d_rdata_d;
        bus.busy    = (state_q == ST_RESP);
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign bus.d_err = bus.d_valid && err_q;
`endif

    always_comb begin : next_state
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_d        = err_q;
        if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end else if (issue) begin
            state_d = ST_RESP;
            owner_d = i_win ? OWN_I : OWN_D;
            we_d    = d_win && bus.d_we;
            err_d   = i_rej || d_rej;
            if (i_win || !bus.i_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            owner_q      <= OWN_D;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed + randomized bench for mips_mem_arbiter with a word-array memory and a
// transaction-level reference model. Honours MEM_ARB_ALIGN_CHECK_EN when defined.
module tb_mips_mem_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             active;
    logic [0:0]       dbg_state;
    logic [CNT_W-1:0] dbg_starve_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic [31:0] exp_q[$];

    mips_mem_arbiter_if bus();

    mips_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    always #5 clk = ~clk;

    // Memory block: registered read data, byte-lane writes.
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_data_out <= mem[bus.mem_address[9:2]];
        if (bus.mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_en[b]) mem[bus.mem_address[9:2]][8*b +: 8] = bus.mem_data_in[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] init_word(input int idx);
        return {16'hC0DE, 16'(idx)};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Stimulus + reference model state
    logic        i_pend, d_pend, win_any, win_i, win_d;
    logic        m_resp, m_own_i, m_was_we;
    int          m_waits;
    logic [31:0] m_last_i, m_last_d, exp_w;
    string       exp_seq;

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]     = (k >= 64 && k < 128) ? init_word(k) : 32'h0;
            exp_mem[k] = mem[k];
        end
        mem[0] = 32'h24020005;
        exp_mem[0] = 32'h24020005;
        reset = 1'b1; active = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_byte_en = '0; bus.d_wdata = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk1("rst_i_gnt", bus.i_gnt, 1'b0);
        chk1("rst_d_gnt", bus.d_gnt, 1'b0);
        chk1("rst_i_valid", bus.i_valid, 1'b0);
        chk1("rst_d_valid", bus.d_valid, 1'b0);
        chk32("rst_i_rdata", bus.i_rdata, 32'h0);
        chk32("rst_d_rdata", bus.d_rdata, 32'h0);
        chk32("rst_mem_address", bus.mem_address, 32'h0);
        chk1("rst_mem_read_en", bus.mem_read_en, 1'b0);
        chk1("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
        chk32("rst_mem_byte_en", 32'(bus.mem_byte_en), 32'h0);
        chk32("rst_mem_data_in", bus.mem_data_in, 32'h0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk32("rst_starve", 32'(dbg_starve_cnt), 32'h0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        chk1("rst_d_err", bus.d_err, 1'b0);
`endif
        tick();
        reset = 1'b0;

        // Single fetch
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC00000;
        @(negedge clk);
        chk1("fetch_i_gnt", bus.i_gnt, 1'b1);
        chk1("fetch_d_gnt", bus.d_gnt, 1'b0);
        chk1("fetch_mem_read_en", bus.mem_read_en, 1'b1);
        chk32("fetch_mem_address", bus.mem_address, 32'hBFC00000);
        chk32("fetch_mem_byte_en", 32'(bus.mem_byte_en), 32'hF);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk1("fetch_i_valid", bus.i_valid, 1'b1);
        chk32("fetch_i_rdata", bus.i_rdata, 32'h24020005);
        chk1("fetch_busy", bus.busy, 1'b1);
        chk1("fetch_resp_no_read", bus.mem_read_en, 1'b0);
        tick();
        @(negedge clk);
        chk1("fetch_idle_valid", bus.i_valid, 1'b0);
        chk1("fetch_idle_busy", bus.busy, 1'b0);
        chk32("fetch_idle_rdata_hold", bus.i_rdata, 32'h24020005);
        tick();

        // D write then D read of the same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_byte_en = 4'b0110;
        bus.d_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk1("dwr_d_gnt", bus.d_gnt, 1'b1);
        chk1("dwr_mem_wr_en", bus.mem_wr_en, 1'b1);
        chk1("dwr_mem_read_en", bus.mem_read_en, 1'b0);
        chk32("dwr_mem_data_in", bus.mem_data_in, 32'hAABBCCDD);
        chk32("dwr_mem_byte_en", 32'(bus.mem_byte_en), 32'h6);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk1("dwr_d_valid", bus.d_valid, 1'b1);
        chk32("dwr_d_rdata_hold", bus.d_rdata, 32'h0);
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_byte_en = 4'b1111; bus.d_wdata = '0;
        @(negedge clk);
        chk1("drd_d_gnt", bus.d_gnt, 1'b1);
        chk1("drd_mem_read_en", bus.mem_read_en, 1'b1);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk1("drd_d_valid", bus.d_valid, 1'b1);
        chk32("drd_d_rdata", bus.d_rdata, 32'h00BBCC00);
        tick();

        // Both ports held: starvation relief every STARVE_LIMIT data wins
        exp_seq = "DDDDIDDDDI";
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104; bus.d_byte_en = 4'b1111;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            chk1("starve_gnt_slot", bus.i_gnt | bus.d_gnt, (cyc % 2) == 0);
            if ((cyc % 2) == 0) begin
                chk1("starve_i_gnt", bus.i_gnt, exp_seq[cyc/2] == "I");
                chk1("starve_d_gnt", bus.d_gnt, exp_seq[cyc/2] == "D");
            end else if (exp_seq[cyc/2] == "I") begin
                chk32("starve_cnt_after_i", 32'(dbg_starve_cnt), 32'h0);
            end
            tick();
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();

        // active drops while a read is in flight
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h108; bus.d_byte_en = 4'b1111;
        @(negedge clk);
        chk1("act_d_gnt", bus.d_gnt, 1'b1);
        tick();
        bus.d_req = 1'b0; active = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10C;
        @(negedge clk);
        chk1("act_d_valid", bus.d_valid, 1'b1);
        chk32("act_d_rdata", bus.d_rdata, init_word(66));
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("act_low_no_gnt", bus.i_gnt | bus.d_gnt, 1'b0);
            chk1("act_low_no_read", bus.mem_read_en, 1'b0);
            tick();
        end
        active = 1'b1;
        @(negedge clk);
        chk1("act_high_i_gnt", bus.i_gnt, 1'b1);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk1("act_i_valid", bus.i_valid, 1'b1);
        chk32("act_i_rdata", bus.i_rdata, init_word(67));
        tick();

        // reset during RESP drops the response
        bus.i_req = 1'b1; bus.i_addr = 32'h110;
        @(negedge clk);
        chk1("rresp_i_gnt", bus.i_gnt, 1'b1);
        tick();
        bus.i_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk1("rresp_i_valid", bus.i_valid, 1'b0);
        chk1("rresp_busy", bus.busy, 1'b0);
        chk32("rresp_state", 32'(dbg_state), 32'h0);
        chk32("rresp_i_rdata", bus.i_rdata, 32'h0);
        chk32("rresp_d_rdata", bus.d_rdata, 32'h0);
        tick();
        bus.i_req = 1'b1;
        @(negedge clk);
        chk1("rresp_reissue_gnt", bus.i_gnt, 1'b1);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk1("rresp_reissue_valid", bus.i_valid, 1'b1);
        chk32("rresp_reissue_rdata", bus.i_rdata, init_word(68));
        tick();

`ifdef MEM_ARB_ALIGN_CHECK_EN
        // Misaligned requests are answered without a memory access
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h11; bus.d_byte_en = 4'b1111;
        bus.d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk1("align_d_gnt", bus.d_gnt, 1'b1);
        chk1("align_mem_wr_en", bus.mem_wr_en, 1'b0);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk1("align_d_err", bus.d_err, 1'b1);
        chk1("align_d_valid", bus.d_valid, 1'b1);
        chk32("align_d_rdata_hold", bus.d_rdata, 32'h0);
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        @(negedge clk);
        chk1("align_rb_gnt", bus.d_gnt, 1'b1);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk32("align_rb_rdata", bus.d_rdata, 32'h00BBCC00);
        chk1("align_rb_no_err", bus.d_err, 1'b0);
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'h102;
        @(negedge clk);
        chk1("align_i_gnt", bus.i_gnt, 1'b1);
        chk1("align_i_no_read", bus.mem_read_en, 1'b0);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk1("align_i_valid", bus.i_valid, 1'b1);
        chk32("align_i_rdata", bus.i_rdata, 32'h0);
        tick();
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        i_pend = 1'b0; d_pend = 1'b0;
        m_resp = 1'b0; m_own_i = 1'b0; m_was_we = 1'b0; m_waits = 0;
        m_last_i = 32'h0; m_last_d = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1'b1;
                bus.i_addr = 32'h100 + ($urandom_range(0, 63) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1;
                bus.d_addr = 32'h100 + ($urandom_range(0, 63) << 2);
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_byte_en = 4'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            bus.i_req = i_pend;
            bus.d_req = d_pend;
            active = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            chk1("rand_busy", bus.busy, m_resp);
            chk32("rand_starve", 32'(dbg_starve_cnt), 32'(m_waits));
            if (m_resp) begin
                chk1("rand_resp_no_gnt", bus.i_gnt | bus.d_gnt, 1'b0);
                chk1("rand_i_valid", bus.i_valid, m_own_i);
                chk1("rand_d_valid", bus.d_valid, !m_own_i);
                if (m_own_i) m_last_i = exp_q.pop_front();
                else if (!m_was_we) m_last_d = exp_q.pop_front();
                m_resp = 1'b0;
            end else begin
                win_any = active && (i_pend || d_pend);
                win_i = win_any && i_pend && (!d_pend || m_waits >= STARVE_LIMIT);
                win_d = win_any && !win_i;
                chk1("rand_i_gnt", bus.i_gnt, win_i);
                chk1("rand_d_gnt", bus.d_gnt, win_d);
                chk1("rand_no_valid", bus.i_valid | bus.d_valid, 1'b0);
                chk1("rand_mem_read_en", bus.mem_read_en, win_i || (win_d && !bus.d_we));
                chk1("rand_mem_wr_en", bus.mem_wr_en, win_d && bus.d_we);
                if (win_i) begin
                    chk32("rand_mem_addr_i", bus.mem_address, bus.i_addr);
                    exp_q.push_back(exp_mem[bus.i_addr[9:2]]);
                    m_waits = 0;
                    i_pend = 1'b0;
                end
                if (win_d) begin
                    chk32("rand_mem_addr_d", bus.mem_address, bus.d_addr);
                    m_waits = i_pend ? ((m_waits < 15) ? m_waits + 1 : 15) : 0;
                    m_was_we = bus.d_we;
                    if (bus.d_we) begin
                        exp_w = exp_mem[bus.d_addr[9:2]];
                        for (int b = 0; b < 4; b++) begin
                            if (bus.d_byte_en[b]) exp_w[8*b +: 8] = bus.d_wdata[8*b +: 8];
                        end
                        exp_mem[bus.d_addr[9:2]] = exp_w;
                    end else begin
                        exp_q.push_back(exp_mem[bus.d_addr[9:2]]);
                    end
                    d_pend = 1'b0;
                end
                m_resp = win_any;
                m_own_i = win_i;
            end
            chk32("rand_i_rdata", bus.i_rdata, m_last_i);
            chk32("rand_d_rdata", bus.d_rdata, m_last_d);
`ifdef MEM_ARB_ALIGN_CHECK_EN
            chk1("rand_d_err", bus.d_err, 1'b0);
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
